// File: rtl/fp32_sub_seq_if.sv
// Operand/result handshake bundle for the sequential fp32 subtractor.
// The master side supplies operands and consumes results.
interface fp32_sub_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/fp32_sub_seq.sv
// Multi-cycle truncating fp32 subtractor (result = a - b).
// Normalisation is iterative, shifting at most NORM_STEP bits per cycle.
module fp32_sub_seq #(
  parameter int unsigned NORM_STEP       = 1,
  parameter bit          FLUSH_SUBNORMAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  fp32_sub_seq_if.slave    io,
  output logic             busy
);

  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic [31:0]         a_q;
  logic [31:0]         bp_q;
  logic                sign_q;
  logic                eff_sub_q;
  logic [EXP_W-1:0]    exp_q;
  logic [MANT_W-1:0]   mant_q;
  logic [MANT_W-1:0]   small_q;
  logic [31:0]         result_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  // Special-operand decode on the incoming pair (b already sign-flipped)
  logic [31:0] b_neg;
  logic        spec_hit;
  logic [31:0] spec_res;
  logic        a_nan, b_nan, a_inf, bn_inf, a_zero, b_zero;

  always_comb begin
    b_neg    = {~io.b[31], io.b[30:0]};
    a_nan    = (&io.a[30:23]) && (|io.a[22:0]);
    b_nan    = (&io.b[30:23]) && (|io.b[22:0]);
    a_inf    = (&io.a[30:23]) && !(|io.a[22:0]);
    bn_inf   = (&b_neg[30:23]) && !(|b_neg[22:0]);
    a_zero   = !(|io.a[30:0]);
    b_zero   = !(|io.b[30:0]);
    spec_hit = 1'b1;
    spec_res = 32'h0;
    if (a_nan)                                      spec_res = io.a;
    else if (b_nan)                                 spec_res = io.b;
    else if (a_inf && bn_inf && (io.a[31] != b_neg[31])) spec_res = 32'h7FC0_0000;
    else if (a_inf)                                 spec_res = io.a;
    else if (bn_inf)                                spec_res = b_neg;
    else if (b_zero)                                spec_res = io.a;
    else if (a_zero)                                spec_res = b_neg;
    else                                            spec_hit = 1'b0;
  end

  // Alignment: subnormals use exponent 1 with hidden bit 0
  logic [EXP_W-1:0]  ea, eb, big_e, small_e, exp_diff;
  logic [MANT_W-1:0] ma, mb, big_m, small_m, small_sh;
  logic              a_big, big_sign;

  always_comb begin
    ea       = (a_q[30:23] == 8'd0) ? 8'd1 : a_q[30:23];
    eb       = (bp_q[30:23] == 8'd0) ? 8'd1 : bp_q[30:23];
    ma       = {|a_q[30:23], a_q[22:0]};
    mb       = {|bp_q[30:23], bp_q[22:0]};
    a_big    = (ea > eb) || ((ea == eb) && (ma >= mb));
    big_e    = a_big ? ea : eb;
    small_e  = a_big ? eb : ea;
    big_m    = a_big ? ma : mb;
    small_m  = a_big ? mb : ma;
    big_sign = a_big ? a_q[31] : bp_q[31];
    exp_diff = big_e - small_e;
    small_sh = (exp_diff >= 8'd24) ? '0 : (small_m >> exp_diff);
  end

  logic [MANT_W:0] sum_c;

  always_comb begin
    if (eff_sub_q) sum_c = {1'b0, mant_q} - {1'b0, small_q};
    else           sum_c = {1'b0, mant_q} + {1'b0, small_q};
  end

  function automatic logic [4:0] lzc24(input logic [MANT_W-1:0] m);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) lzc24 = 5'(23 - i);
    end
  endfunction

  // Per-cycle shift: bounded by step, leading zeros and exponent headroom
  logic [4:0]       lz_c;
  logic [4:0]       sh_c;
  logic [EXP_W-1:0] exp_room;

  always_comb begin
    lz_c     = lzc24(mant_q);
    exp_room = exp_q - 8'd1;
    sh_c     = 5'(NORM_STEP);
    if (lz_c < sh_c) sh_c = lz_c;
    if (exp_room < 8'(sh_c)) sh_c = 5'(exp_room);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      bp_q        <= '0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      small_q     <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.in_valid) begin
            a_q        <= io.a;
            bp_q       <= b_neg;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (spec_hit) begin
              result_q    <= spec_res;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          sign_q    <= big_sign;
          exp_q     <= big_e;
          mant_q    <= big_m;
          small_q   <= small_sh;
          eff_sub_q <= a_q[31] ^ bp_q[31];
          state_q   <= S_ADD;
        end
        S_ADD: begin
          if (sum_c[MANT_W]) begin
            if (exp_q == 8'd254) result_q <= {sign_q, 8'hFF, 23'h0};
            else                 result_q <= {sign_q, 8'(exp_q + 8'd1), sum_c[23:1]};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (sum_c == '0) begin
            result_q    <= 32'h0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            mant_q  <= sum_c[MANT_W-1:0];
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          if (mant_q[23]) begin
            result_q    <= {sign_q, exp_q, mant_q[22:0]};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (exp_q == 8'd1) begin
            // Exponent floor reached without a leading one: subnormal
            result_q    <= FLUSH_SUBNORMAL ? {sign_q, 31'h0} : {sign_q, 8'h00, mant_q[22:0]};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            mant_q <= mant_q << sh_c;
            exp_q  <= exp_q - 8'(sh_c);
          end
        end
        S_DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign busy         = busy_q;

endmodule

// File: doc/fp32_sub_seq.md
Name: fp32_sub_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor that computes result = a - b.
- It is the subtract-direction companion to the combinational fp32 adder. It uses the same truncating arithmetic and the same subnormal convention (exponent 0 is treated as exponent 1 with a hidden bit of 0).
- Normalisation is iterative and bounded, trading latency for area. Used in accumulator/reduction datapaths where back-pressure is needed.
- Operands arrive over a valid/ready handshake; the result leaves over a second valid/ready handshake.

Parameters:
- NORM_STEP, default 1: maximum left-shift bits per normalisation cycle. Legal values are 1, 2, 4.
- FLUSH_SUBNORMAL, default 0: when 1, subnormal results are output as signed zero.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  32  minuend, fp32.
- b  input  32  subtrahend, fp32.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  32  a - b, fp32.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low asynchronously forces state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, and clears all datapath registers.
  - Reset mid-operation abandons the operation; no partial result is emitted.
- States: IDLE, ALIGN, ADD, NORM, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - result is registered and held stable while out_valid=1 and out_ready=0.
- IDLE:
  - On in_valid & in_ready, capture a and b' = {~b[31], b[30:0]}.
  - Evaluate special cases in priority order. If one matches, load result and go to DONE (out_valid one cycle after accept):
    1. a is NaN: result=a.
    2. b is NaN: result=b unchanged (no sign flip).
    3. a=inf and b'=inf with opposite signs: result=0x7FC00000.
    4. a is inf: result=a.
    5. b' is inf: result=b'.
    6. b is ±0: result=a.
    7. a is ±0: result=b'.
  - Otherwise go to ALIGN.
- ALIGN:
  - Operand with the larger exponent is the big operand, or the larger mantissa when exponents are equal.
  - Output sign = big operand's sign; working exponent = big exponent.
  - Small mantissa is logically right-shifted by the exponent difference (truncated, no guard/sticky). Differences ≥24 give 0.
  - Next state: ADD.
- ADD:
  - 25-bit mantissa sum if effective signs are equal, else difference big-small.
  - If sum bit 24 is set: shift right 1 and increment exponent. If the exponent then equals 255, result = ±inf (mantissa 0).
  - If the mantissa is 0: result = +0 (0x00000000).
  - All three of these cases go to DONE. Otherwise go to NORM.
- NORM, once per cycle:
  - Stop condition: bit 23 set, or exponent==1.
  - If not stopped: shift left by min(NORM_STEP, leading zeros above bit 23, exponent-1) and decrement the exponent by the same amount. Shifts never pass the leading one and the exponent never goes below 1.
  - When stopped, go to DONE, with one exception: exponent==1 and bit 23 = 0 gives a subnormal, output with exponent field 0, or ±0 if FLUSH_SUBNORMAL=1.
  - Rounding is truncation only.
- DONE:
  - On out_ready, go to IDLE. in_ready rises on the following cycle; there is no same-cycle accept on the result handshake.
- Latency (accept edge to out_valid rising):
  - Special case: 1.
  - Regular: 3 + k, where k = NORM cycles entered, counting the final stopping cycle. k=0 when NORM is skipped.
  - Worst case with NORM_STEP=1: 3+24.
- Inputs a and b are ignored outside IDLE; in_valid may stay high.

Test Plan:
1. a=0x40400000 (3.0), b=0x3F800000 (1.0) -> result=0x40000000, k=1 (NORM stops immediately, bit 23 already set), out_valid 4 cycles after accept; a=b=0x3F800000 -> 0x00000000 (ADD zero path, 3 cycles).
2. a=0x3F800000, b=0xBF800000 (1.0 - -1.0) -> carry path, result=0x40000000, latency 3; a=b=0x7F7FFFFF with b sign flipped (max+max) -> 0x7F800000.
3. a=0x3F800001, b=0x3F800000, NORM_STEP=1 -> result=0x34000000 after 23 shift cycles (k=24, latency 27); with NORM_STEP=4 -> same value, k=7 (6 shift cycles + stop).
4. a=b=0x7F800000 -> 0x7FC00000; a=0x7FC00001 with any b -> 0x7FC00001; a=0x00000000, b=0x3F800000 -> 0xBF800000; all with latency 1.
5. Subnormal: a=0x00800001, b=0x00800000 -> 0x00000001 (FLUSH_SUBNORMAL=0) or 0x00000000 (=1). Then hold out_ready=0 for 5 cycles -> result stable, in_ready=0; raise out_ready -> IDLE next cycle, next operand accepted the cycle after.
6. Pulse rst_n low during NORM of scenario 3 -> out_valid=0, result=0, in_ready=1 immediately. After release, scenario 1 completes with the correct value and latency.
